sssp_core_dispatch: RTL and testbench
=====================================

Name: sssp_core_dispatch

Overview:
- Distributes incoming SSSP tasks from the task-queue output stream to N_CORES sssp_core instances.
- Drives each core's ap_start/task_in handshake and tracks each core through to ap_done; a core's task_in is held stable for the whole task.
- Round-robin among free cores; exposes occupancy, counters and a sticky protocol-error flag to the tile controller.

Parameters:
N_CORES, 4, number of attached cores (2..16)
TASK_WIDTH, TQ_WIDTH, width of a packed task word {args, ttype, object, ts}

Ports:
clk  input  1  clock
rstn  input  1  synchronous reset, active-low
enable  input  1  when 0, no new tasks accepted; running tasks complete
s_task_valid  input  1  task available
s_task_ready  output  1  dispatcher accepts task this cycle
s_task_data  input  TASK_WIDTH  packed task
core_start  output  N_CORES  ap_start per core
core_task  output  N_CORES*TASK_WIDTH  task_in per core; slice i = bits [i*TASK_WIDTH +: TASK_WIDTH]
core_ready  input  N_CORES  ap_ready per core
core_done  input  N_CORES  ap_done per core (1-cycle pulse)
busy_mask  output  N_CORES  bit i = core i not FREE
all_idle  output  1  all cores FREE
dispatch_count  output  32  tasks accepted, wraps mod 2^32
done_count  output  32  tasks completed, wraps mod 2^32
proto_error  output  1  sticky protocol violation flag

Behaviour:
- Per-core 2-bit state: FREE -> START -> RUN -> FREE.
- FREE:
  - eligible for grant.
  - core_done seen here sets proto_error; state does not change.
- START:
  - core_start[i]=1, held until core_ready[i]=1; same cycle -> RUN.
  - core_done[i] seen here sets proto_error.
- RUN:
  - core_start[i]=0; core_done[i]=1 -> FREE next cycle, done_count+1.
  - core_ready[i] is ignored in RUN.
- Handshake and grant:
  - s_task_ready = enable & (any core FREE); combinational from registered state only.
  - Accept on s_task_valid & s_task_ready.
  - Grant goes to the first FREE core at index >= rr_ptr, searching cyclically.
  - On accept: core_task slice of the granted core <= s_task_data; granted core -> START; rr_ptr <= (grant+1) mod N_CORES; dispatch_count+1.
- Latency:
  - Accept at cycle T -> core_start asserted from T+1.
  - done at cycle T -> that core can be granted at T+1.
  - No same-cycle reuse on done.
- core_task registers hold after the task finishes until the next grant to that core; no other writes.
- One grant per cycle maximum. Simultaneous done on several cores: all free next cycle, and done_count adds popcount(core_done & RUN mask).
- busy_mask and all_idle are derived from registered state.
- enable deasserted mid-START: core_start stays high until core_ready (no abort).
- proto_error clears only on reset.
- Reset (any time, including mid-task):
  - all cores FREE, rr_ptr=0, counters=0, proto_error=0, core_start=0, core_task=0, s_task_ready=0 during reset.
  - Cores are reset by the same rstn; no in-flight task is tracked.

Test Plan:
- Single task, N_CORES=4, core_ready=1 in cycle after start, done 20 cycles later -> core 0 granted, core_start[0] high for 1 cycle, core_task[0] equals input, dispatch_count=1, done_count=1, all_idle=1 after done.
- 6 back-to-back valid tasks, cores never finish -> grants to cores 0,1,2,3; s_task_ready=0 after 4th accept; tasks 5,6 stall; busy_mask=4'b1111.
- Core 2 finishes while cores 0,1,3 busy, rr_ptr=0 -> next task goes to core 2 one cycle after done; rr_ptr becomes 3.
- core_ready held low 10 cycles after accept -> core_start stays high 10+ cycles; core_task slice unchanged; state RUN only after ready.
- Spurious core_done[1] while core 1 FREE -> proto_error=1 and stays 1; done_count unchanged; reset clears it.
- Reset asserted with 3 cores RUN and enable=0 afterward -> all outputs zero; after release s_task_ready=0 until enable=1, then first grant to core 0.

Source files
------------

// File: rtl/sssp_core_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : sssp_core_dispatch_if
// Description : Task-stream and per-core start/done handshake bundle between
//               the task queue, the dispatcher and the attached sssp_cores.
// Revision    : 1.0 - initial release
// ============================================================================
interface sssp_core_dispatch_if #(
    parameter int N_CORES    = 4,
    parameter int TASK_WIDTH = 64
);
    logic                          s_task_valid;
    logic                          s_task_ready;
    logic [TASK_WIDTH-1:0]         s_task_data;
    logic [N_CORES-1:0]            core_start;
    logic [N_CORES*TASK_WIDTH-1:0] core_task;
    logic [N_CORES-1:0]            core_ready;
    logic [N_CORES-1:0]            core_done;

    // Dispatcher side
    modport master (
        input  s_task_valid, s_task_data, core_ready, core_done,
        output s_task_ready, core_start, core_task
    );

    // Task source / core side
    modport slave (
        output s_task_valid, s_task_data, core_ready, core_done,
        input  s_task_ready, core_start, core_task
    );
endinterface
`default_nettype wire

// File: rtl/sssp_core_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : sssp_core_dispatch
// Description : Round-robin dispatcher feeding SSSP tasks from the task queue
//               to N_CORES sssp_core instances. Tracks each core through
//               FREE -> START -> RUN -> FREE, holds task_in stable per core,
//               and reports occupancy, counters and a sticky protocol error.
// Revision    : 1.0 - initial release
// ============================================================================
module sssp_core_dispatch #(
    parameter int N_CORES    = 4,
    // Packed task word {args, ttype, object, ts}; matches the task-queue width
    parameter int TASK_WIDTH = 64
) (
    input  wire logic                clk,
    input  wire logic                rstn,
    input  wire logic                enable,
    sssp_core_dispatch_if.master     bus,
    output logic [N_CORES-1:0]       busy_mask,
    output logic                     all_idle,
    output logic [31:0]              dispatch_count,
    output logic [31:0]              done_count,
    output logic                     proto_error
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } core_state_e;

    core_state_e                   state_q [N_CORES];
    core_state_e                   state_d [N_CORES];
    logic [N_CORES-1:0]            start_q, start_d;
    logic [N_CORES*TASK_WIDTH-1:0] core_task_q, core_task_d;
    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [31:0]                   dispatch_count_q, dispatch_count_d;
    logic [31:0]                   done_count_q, done_count_d;
    logic                          proto_error_q, proto_error_d;

    logic [N_CORES-1:0]            free_mask;
    logic [N_CORES-1:0]            run_mask;
    logic                          task_ready;
    logic                          accept;
    logic                          grant_found;
    logic [PTR_W-1:0]              grant_idx;
    int                            cand;
    logic [31:0]                   done_inc;
    logic                          err_set;

    // Occupancy masks decoded from registered per-core state
    always_comb begin
        free_mask = '0;
        run_mask  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            free_mask[i] = (state_q[i] == ST_FREE);
            run_mask[i]  = (state_q[i] == ST_RUN);
        end
    end

    // Ready depends only on registered state; forced low while in reset
    assign task_ready = rstn & enable & (|free_mask);
    assign accept     = bus.s_task_valid & task_ready;

    // Cyclic search for the first FREE core at or after rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < N_CORES; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_CORES) begin
                cand = cand - N_CORES;
            end
            if (!grant_found && free_mask[PTR_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // Next-state for per-core FSMs, task registers, pointer and counters
    always_comb begin
        start_d          = start_q;
        core_task_d      = core_task_q;
        rr_ptr_d         = rr_ptr_q;
        dispatch_count_d = dispatch_count_q;
        done_inc         = '0;
        err_set          = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (bus.core_done[i]) begin
                        err_set = 1'b1;
                    end
                    if (accept && grant_found && (grant_idx == PTR_W'(i))) begin
                        state_d[i] = ST_START;
                        core_task_d[i*TASK_WIDTH +: TASK_WIDTH] = bus.s_task_data;
                    end
                end
                ST_START: begin
                    if (bus.core_done[i]) begin
                        err_set = 1'b1;
                    end
                    if (bus.core_ready[i]) begin
                        state_d[i] = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // ap_ready is not meaningful once the core is running
                    if (bus.core_done[i]) begin
                        state_d[i] = ST_FREE;
                        done_inc   = done_inc + 32'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_FREE;
                end
            endcase
            start_d[i] = (state_d[i] == ST_START);
        end
        if (accept && grant_found) begin
            rr_ptr_d         = (grant_idx == PTR_W'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;
            dispatch_count_d = dispatch_count_q + 32'd1;
        end
        done_count_d  = done_count_q + done_inc;
        proto_error_d = proto_error_q | err_set;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_CORES; i++) begin
                state_q[i] <= ST_FREE;
            end
            start_q          <= '0;
            core_task_q      <= '0;
            rr_ptr_q         <= '0;
            dispatch_count_q <= '0;
            done_count_q     <= '0;
            proto_error_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                state_q[i] <= state_d[i];
            end
            start_q          <= start_d;
            core_task_q      <= core_task_d;
            rr_ptr_q         <= rr_ptr_d;
            dispatch_count_q <= dispatch_count_d;
            done_count_q     <= done_count_d;
            proto_error_q    <= proto_error_d;
        end
    end

    assign bus.s_task_ready = task_ready;
    assign bus.core_start   = start_q;
    assign bus.core_task    = core_task_q;
    assign busy_mask        = ~free_mask;
    assign all_idle         = &free_mask;
    assign dispatch_count   = dispatch_count_q;
    assign done_count       = done_count_q;
    assign proto_error      = proto_error_q;

endmodule
`default_nettype wire

// File: tb/tb_sssp_core_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sssp_core_dispatch
// Description : Directed self-checking bench for sssp_core_dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sssp_core_dispatch;

    localparam int NC = 4;
    localparam int TW = 64;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [NC-1:0] busy_mask;
    logic        all_idle;
    logic [31:0] dispatch_count;
    logic [31:0] done_count;
    logic        proto_error;

    int checks;
    int failures;

    sssp_core_dispatch_if #(.N_CORES(NC), .TASK_WIDTH(TW)) bus ();

    sssp_core_dispatch #(.N_CORES(NC), .TASK_WIDTH(TW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .bus           (bus),
        .busy_mask     (busy_mask),
        .all_idle      (all_idle),
        .dispatch_count(dispatch_count),
        .done_count    (done_count),
        .proto_error   (proto_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] slice(input int k);
        logic [NC*TW-1:0] v;
        v = bus.core_task;
        return v[k*TW +: TW];
    endfunction

    task automatic apply_reset();
        rstn             = 1'b0;
        bus.s_task_valid = 1'b0;
        bus.s_task_data  = '0;
        bus.core_ready   = '0;
        bus.core_done    = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        apply_reset();
        checks++; if (bus.s_task_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", bus.s_task_ready); end
        checks++; if (bus.core_start !== 4'b0000) begin failures++; $display("FAIL reset_start got=%b want=0000", bus.core_start); end
        checks++; if (bus.core_task !== '0) begin failures++; $display("FAIL reset_task got=%h want=0", bus.core_task); end
        checks++; if (busy_mask !== 4'b0000 || all_idle !== 1'b1) begin failures++; $display("FAIL reset_busy busy=%b idle=%b want 0000/1", busy_mask, all_idle); end
        checks++; if (dispatch_count !== 32'd0 || done_count !== 32'd0 || proto_error !== 1'b0) begin failures++; $display("FAIL reset_counters disp=%0d done=%0d err=%b want 0/0/0", dispatch_count, done_count, proto_error); end
        enable = 1'b1;
        #1;
        checks++; if (bus.s_task_ready !== 1'b1) begin failures++; $display("FAIL reset_enable_ready got=%b want=1", bus.s_task_ready); end
    endtask

    task automatic test_single();
        logic [TW-1:0] d0;
        d0 = 64'h0123_4567_89AB_CDEF;
        apply_reset();
        enable           = 1'b1;
        bus.s_task_valid = 1'b1;
        bus.s_task_data  = d0;
        step();
        bus.s_task_valid = 1'b0;
        bus.s_task_data  = '0;
        checks++; if (bus.core_start !== 4'b0001) begin failures++; $display("FAIL single_start got=%b want=0001", bus.core_start); end
        checks++; if (slice(0) !== d0) begin failures++; $display("FAIL single_task got=%h want=%h", slice(0), d0); end
        checks++; if (dispatch_count !== 32'd1) begin failures++; $display("FAIL single_disp got=%0d want=1", dispatch_count); end
        bus.core_ready = 4'b0001;
        step();
        bus.core_ready = 4'b0000;
        checks++; if (bus.core_start !== 4'b0000 || busy_mask !== 4'b0001) begin failures++; $display("FAIL single_run start=%b busy=%b want 0000/0001", bus.core_start, busy_mask); end
        for (int c = 0; c < 19; c++) step();
        bus.core_done = 4'b0001;
        step();
        bus.core_done = 4'b0000;
        checks++; if (all_idle !== 1'b1 || done_count !== 32'd1) begin failures++; $display("FAIL single_done idle=%b done=%0d want 1/1", all_idle, done_count); end
        checks++; if (slice(0) !== d0 || proto_error !== 1'b0) begin failures++; $display("FAIL single_hold task=%h err=%b want %h/0", slice(0), proto_error, d0); end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] base;
        base = 64'hA000_0000_0000_0000;
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.s_task_valid = 1'b1;
            bus.s_task_data  = base + 64'(c);
            #1;
            checks++; if (bus.s_task_ready !== (c < 4)) begin failures++; $display("FAIL b2b_ready cycle=%0d got=%b want=%b", c, bus.s_task_ready, (c < 4)); end
            step();
        end
        bus.s_task_valid = 1'b0;
        checks++; if (busy_mask !== 4'b1111 || dispatch_count !== 32'd4) begin failures++; $display("FAIL b2b_busy busy=%b disp=%0d want 1111/4", busy_mask, dispatch_count); end
        checks++; if (bus.core_start !== 4'b1111) begin failures++; $display("FAIL b2b_start got=%b want=1111", bus.core_start); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (slice(k) !== base + 64'(k)) begin failures++; $display("FAIL b2b_task core=%0d got=%h want=%h", k, slice(k), base + 64'(k)); end
        end
    endtask

    // Continues from test_back_to_back: all four cores in START, rr_ptr = 0
    task automatic test_rr_reuse();
        logic [TW-1:0] dx, dy, dz;
        dx = 64'hDDDD_0000_0000_0002;
        dy = 64'hDDDD_0000_0000_0003;
        dz = 64'hDDDD_0000_0000_0000;
        bus.core_ready = 4'b1111;
        step();
        bus.core_ready = 4'b0000;
        bus.core_done  = 4'b0100;
        step();
        bus.core_done  = 4'b0000;
        checks++; if (busy_mask !== 4'b1011 || done_count !== 32'd1 || bus.s_task_ready !== 1'b1) begin failures++; $display("FAIL rr_free2 busy=%b done=%0d rdy=%b want 1011/1/1", busy_mask, done_count, bus.s_task_ready); end
        bus.s_task_valid = 1'b1;
        bus.s_task_data  = dx;
        step();
        bus.s_task_valid = 1'b0;
        checks++; if (bus.core_start !== 4'b0100 || slice(2) !== dx) begin failures++; $display("FAIL rr_grant2 start=%b task=%h want 0100/%h", bus.core_start, slice(2), dx); end
        bus.core_ready = 4'b0100;
        step();
        bus.core_ready = 4'b0000;
        bus.core_done  = 4'b1001;
        step();
        bus.core_done  = 4'b0000;
        checks++; if (done_count !== 32'd3 || busy_mask !== 4'b0110) begin failures++; $display("FAIL rr_multi_done done=%0d busy=%b want 3/0110", done_count, busy_mask); end
        bus.s_task_valid = 1'b1;
        bus.s_task_data  = dy;
        step();
        checks++; if (bus.core_start !== 4'b1000 || slice(3) !== dy) begin failures++; $display("FAIL rr_ptr3 start=%b task=%h want 1000/%h", bus.core_start, slice(3), dy); end
        bus.s_task_data = dz;
        step();
        bus.s_task_valid = 1'b0;
        checks++; if (bus.core_start !== 4'b1001 || slice(0) !== dz) begin failures++; $display("FAIL rr_wrap start=%b task=%h want 1001/%h", bus.core_start, slice(0), dz); end
        checks++; if (proto_error !== 1'b0) begin failures++; $display("FAIL rr_err got=%b want=0", proto_error); end
    endtask

    task automatic test_ready_stall();
        logic [TW-1:0] ds;
        int bad;
        ds  = 64'h5555_AAAA_1234_0001;
        bad = 0;
        apply_reset();
        enable           = 1'b1;
        bus.s_task_valid = 1'b1;
        bus.s_task_data  = ds;
        step();
        bus.s_task_valid = 1'b0;
        bus.s_task_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        enable           = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.core_start !== 4'b0001 || slice(0) !== ds) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold bad_cycles=%0d want 0 (start=%b task=%h)", bad, bus.core_start, slice(0)); end
        checks++; if (bus.s_task_ready !== 1'b0) begin failures++; $display("FAIL stall_disabled_ready got=%b want=0", bus.s_task_ready); end
        bus.core_ready = 4'b0001;
        step();
        bus.core_ready = 4'b0000;
        checks++; if (bus.core_start !== 4'b0000) begin failures++; $display("FAIL stall_release got=%b want=0000", bus.core_start); end
        bus.core_done = 4'b0001;
        step();
        bus.core_done = 4'b0000;
        checks++; if (done_count !== 32'd1 || proto_error !== 1'b0 || all_idle !== 1'b1) begin failures++; $display("FAIL stall_done done=%0d err=%b idle=%b want 1/0/1", done_count, proto_error, all_idle); end
    endtask

    task automatic test_spurious_done();
        apply_reset();
        enable        = 1'b0;
        bus.core_done = 4'b0010;
        step();
        bus.core_done = 4'b0000;
        checks++; if (proto_error !== 1'b1 || done_count !== 32'd0) begin failures++; $display("FAIL spur_set err=%b done=%0d want 1/0", proto_error, done_count); end
        checks++; if (busy_mask !== 4'b0000) begin failures++; $display("FAIL spur_state busy=%b want 0000", busy_mask); end
        step();
        step();
        checks++; if (proto_error !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b want=1", proto_error); end
        apply_reset();
        checks++; if (proto_error !== 1'b0) begin failures++; $display("FAIL spur_clear got=%b want=0", proto_error); end
    endtask

    task automatic test_reset_midtask();
        logic [TW-1:0] dr;
        dr = 64'hCAFE_F00D_0000_0007;
        apply_reset();
        enable           = 1'b1;
        bus.core_ready   = 4'b1111;
        bus.s_task_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.s_task_data = 64'h1000 + 64'(c);
            step();
        end
        bus.s_task_valid = 1'b0;
        step();
        checks++; if (busy_mask !== 4'b0111 || bus.core_start !== 4'b0000 || dispatch_count !== 32'd3) begin failures++; $display("FAIL mid_run busy=%b start=%b disp=%0d want 0111/0000/3", busy_mask, bus.core_start, dispatch_count); end
        rstn           = 1'b0;
        enable         = 1'b0;
        bus.core_ready = 4'b0000;
        #1;
        checks++; if (bus.s_task_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b want=0", bus.s_task_ready); end
        step();
        checks++; if (busy_mask !== 4'b0000 || all_idle !== 1'b1 || bus.core_task !== '0 || dispatch_count !== 32'd0) begin failures++; $display("FAIL mid_rst_state busy=%b idle=%b disp=%0d want 0000/1/0", busy_mask, all_idle, dispatch_count); end
        rstn             = 1'b1;
        bus.s_task_valid = 1'b1;
        bus.s_task_data  = dr;
        step();
        checks++; if (bus.s_task_ready !== 1'b0 || bus.core_start !== 4'b0000) begin failures++; $display("FAIL mid_disabled rdy=%b start=%b want 0/0000", bus.s_task_ready, bus.core_start); end
        enable = 1'b1;
        step();
        bus.s_task_valid = 1'b0;
        checks++; if (bus.core_start !== 4'b0001 || slice(0) !== dr) begin failures++; $display("FAIL mid_first_grant start=%b task=%h want 0001/%h", bus.core_start, slice(0), dr); end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rstn             = 1'b0;
        enable           = 1'b0;
        bus.s_task_valid = 1'b0;
        bus.s_task_data  = '0;
        bus.core_ready   = '0;
        bus.core_done    = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_rr_reuse();
        test_ready_stall();
        test_spurious_done();
        test_reset_midtask();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
